// File: rtl/udp_rx_filter.sv
// udp_rx_filter: receive-side Ethernet II / IPv4 / UDP header walker.
//
// Walks the 42-byte header of each MAC frame. Only IPv4 frames without options,
// carrying UDP and addressed to LOCAL_IP:LOCAL_PORT are accepted. The UDP payload
// of an accepted frame is forwarded one byte per cycle with a one-cycle latency.
// Every other frame is discarded and flagged with a single drop pulse.
//
// Ports:
//   clk      system clock
//   rstn     asynchronous active-low reset
//   rx_dv    MAC byte valid, high for the whole frame (preamble/SFD already stripped)
//   rx_byte  MAC frame byte
//   valid    payload byte strobe
//   o_data   payload byte, qualified by valid
//   rx_end   one-cycle pulse, one cycle after the last valid of an accepted datagram
//   o_len    declared payload length (UDP length - 8), held until the next frame's byte 39
//   trunc    high with rx_end when the frame ended before o_len bytes were emitted
//   drop     one-cycle pulse for a rejected frame
module udp_rx_filter #(
  parameter logic [31:0] LOCAL_IP   = 32'hC0A8_0102,
  parameter logic [15:0] LOCAL_PORT = 16'd8080
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        rx_dv,
  input  logic [7:0]  rx_byte,
  output logic        valid,
  output logic [7:0]  o_data,
  output logic        rx_end,
  output logic [15:0] o_len,
  output logic        trunc,
  output logic        drop
);

  // StEnd is the single cycle between the last payload byte and the rx_end pulse,
  // so that rx_end lands exactly one cycle after the last valid.
  typedef enum logic [2:0] {
    StIdle,
    StHeader,
    StPayload,
    StEnd,
    StTail,
    StDrop
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  hidx_q, hidx_d;
  logic [15:0] pcnt_q, pcnt_d;
  logic [7:0]  len_hi_q, len_hi_d;
  logic        valid_q, valid_d;
  logic [7:0]  o_data_q, o_data_d;
  logic        rx_end_q, rx_end_d;
  logic        trunc_q, trunc_d;
  logic        drop_q, drop_d;
  logic [15:0] o_len_q, o_len_d;

  logic [15:0] udp_len;
  logic [15:0] pcnt_inc;
  logic        hdr_ok;

  assign udp_len  = {len_hi_q, rx_byte};
  assign pcnt_inc = pcnt_q + 16'd1;

  // Per-byte header check; bytes not listed are don't-care (MACs, checksums, ...).
  always_comb begin
    hdr_ok = 1'b1;
    case (hidx_q)
      6'd12:   hdr_ok = (rx_byte == 8'h08);
      6'd13:   hdr_ok = (rx_byte == 8'h00);
      6'd14:   hdr_ok = (rx_byte == 8'h45);
      6'd23:   hdr_ok = (rx_byte == 8'h11);
      6'd30:   hdr_ok = (rx_byte == LOCAL_IP[31:24]);
      6'd31:   hdr_ok = (rx_byte == LOCAL_IP[23:16]);
      6'd32:   hdr_ok = (rx_byte == LOCAL_IP[15:8]);
      6'd33:   hdr_ok = (rx_byte == LOCAL_IP[7:0]);
      6'd36:   hdr_ok = (rx_byte == LOCAL_PORT[15:8]);
      6'd37:   hdr_ok = (rx_byte == LOCAL_PORT[7:0]);
      6'd39:   hdr_ok = (udp_len >= 16'd8);
      default: hdr_ok = 1'b1;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    hidx_d   = hidx_q;
    pcnt_d   = pcnt_q;
    len_hi_d = len_hi_q;
    valid_d  = 1'b0;
    o_data_d = o_data_q;
    rx_end_d = 1'b0;
    trunc_d  = 1'b0;
    drop_d   = 1'b0;
    o_len_d  = o_len_q;

    case (state_q)
      StIdle: begin
        if (rx_dv) begin
          // Byte 0 (first destination MAC byte) is consumed unchecked.
          hidx_d  = 6'd1;
          state_d = StHeader;
        end
      end

      StHeader: begin
        if (!rx_dv) begin
          drop_d  = 1'b1;
          state_d = StIdle;
        end else begin
          hidx_d = hidx_q + 6'd1;
          if (hidx_q == 6'd38) begin
            len_hi_d = rx_byte;
          end
          if (!hdr_ok) begin
            drop_d  = 1'b1;
            state_d = StDrop;
          end else begin
            if (hidx_q == 6'd39) begin
              o_len_d = udp_len - 16'd8;
            end
            if (hidx_q == 6'd41) begin
              pcnt_d = 16'd0;
              // o_len_q already holds this frame's length (registered after byte 39).
              if (o_len_q == 16'd0) begin
                rx_end_d = 1'b1;
                state_d  = StTail;
              end else begin
                state_d = StPayload;
              end
            end
          end
        end
      end

      StPayload: begin
        if (rx_dv) begin
          valid_d  = 1'b1;
          o_data_d = rx_byte;
          pcnt_d   = pcnt_inc;
          if (pcnt_inc == o_len_q) begin
            state_d = StEnd;
          end
        end else begin
          // The last valid is on the output this cycle, so rx_end follows next cycle.
          rx_end_d = 1'b1;
          trunc_d  = 1'b1;
          state_d  = StIdle;
        end
      end

      StEnd: begin
        rx_end_d = 1'b1;
        // A frame ending right after its payload must not swallow the next frame.
        state_d  = rx_dv ? StTail : StIdle;
      end

      StTail, StDrop: begin
        if (!rx_dv) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StTail;
      end
    endcase
  end

  // Reset lands in StTail so a frame already in flight is ignored until rx_dv drops.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= StTail;
      hidx_q   <= 6'd0;
      pcnt_q   <= 16'd0;
      len_hi_q <= 8'd0;
      valid_q  <= 1'b0;
      o_data_q <= 8'd0;
      rx_end_q <= 1'b0;
      trunc_q  <= 1'b0;
      drop_q   <= 1'b0;
      o_len_q  <= 16'd0;
    end else begin
      state_q  <= state_d;
      hidx_q   <= hidx_d;
      pcnt_q   <= pcnt_d;
      len_hi_q <= len_hi_d;
      valid_q  <= valid_d;
      o_data_q <= o_data_d;
      rx_end_q <= rx_end_d;
      trunc_q  <= trunc_d;
      drop_q   <= drop_d;
      o_len_q  <= o_len_d;
    end
  end

  assign valid  = valid_q;
  assign o_data = o_data_q;
  assign rx_end = rx_end_q;
  assign trunc  = trunc_q;
  assign drop   = drop_q;
  assign o_len  = o_len_q;

endmodule

// File: tb/tb_udp_rx_filter.sv
// Scoreboard bench for udp_rx_filter: stimulus pushes expected output events
// (payload byte, end of datagram, drop) with their expected cycle; a monitor pops
// and compares every output event the DUT presents.
module tb_udp_rx_filter;

  logic        clk;
  logic        rstn;
  logic        rx_dv;
  logic [7:0]  rx_byte;
  logic        valid;
  logic [7:0]  o_data;
  logic        rx_end;
  logic [15:0] o_len;
  logic        trunc;
  logic        drop;

  udp_rx_filter #(
    .LOCAL_IP   (32'hC0A8_0102),
    .LOCAL_PORT (16'd8080)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .rx_dv   (rx_dv),
    .rx_byte (rx_byte),
    .valid   (valid),
    .o_data  (o_data),
    .rx_end  (rx_end),
    .o_len   (o_len),
    .trunc   (trunc),
    .drop    (drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {EvValid, EvEnd, EvDrop} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    logic [7:0]  data;
    logic [15:0] len;
    logic        tr;
    int          cyc;
  } ev_t;

  ev_t         exp_q[$];
  logic [7:0]  frm[$];
  logic [7:0]  pay_q[$];
  int          checks   = 0;
  int          failures = 0;
  int          s;
  logic [15:0] last_len;

  task automatic push_ev(input ev_kind_e k, input logic [7:0] d, input logic [15:0] l,
                         input logic t, input int c);
    ev_t e;
    e.kind = k;
    e.data = d;
    e.len  = l;
    e.tr   = t;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic check_ev(input ev_kind_e k);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event: got kind=%0d cyc=%0d data=%02h len=%0d, expected none",
               k, cyc, o_data, o_len);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.cyc != cyc || e.len != o_len || e.tr != trunc ||
          (k == EvValid && e.data != o_data)) begin
        failures++;
        $display("FAIL event: got kind=%0d cyc=%0d data=%02h len=%0d trunc=%0b, expected kind=%0d cyc=%0d data=%02h len=%0d trunc=%0b",
                 k, cyc, o_data, o_len, trunc, e.kind, e.cyc, e.data, e.len, e.tr);
      end
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rstn) begin
      if (valid) check_ev(EvValid);
      if (rx_end) begin
        checks++;
        if (valid) begin
          failures++;
          $display("FAIL valid_with_rx_end: got valid=1, expected valid=0 at cyc=%0d", cyc);
        end
        check_ev(EvEnd);
      end
      if (drop) check_ev(EvDrop);
      if (trunc && !rx_end) begin
        checks++;
        failures++;
        $display("FAIL trunc_alone: got trunc=1 rx_end=0, expected trunc only with rx_end");
      end
    end
  end

  task automatic fill_pay(input int n, input logic [7:0] seed);
    pay_q.delete();
    for (int i = 0; i < n; i++) pay_q.push_back(8'(seed + 8'(i * 3)));
  endtask

  task automatic build(input logic [15:0] et, input logic [7:0] proto, input logic [15:0] port,
                       input logic [15:0] ulen, input int ntail);
    logic [15:0] tot;
    tot = ulen + 16'd20;
    frm.delete();
    for (int i = 0; i < 6; i++) frm.push_back(8'h02 + 8'(i));   // dst MAC
    for (int i = 0; i < 6; i++) frm.push_back(8'h10 + 8'(i));   // src MAC
    frm.push_back(et[15:8]);  frm.push_back(et[7:0]);
    frm.push_back(8'h45);     frm.push_back(8'h00);
    frm.push_back(tot[15:8]); frm.push_back(tot[7:0]);
    frm.push_back(8'h12);     frm.push_back(8'h34);
    frm.push_back(8'h40);     frm.push_back(8'h00);
    frm.push_back(8'h40);     frm.push_back(proto);
    frm.push_back(8'hB7);     frm.push_back(8'h3A);             // IP checksum, unchecked
    frm.push_back(8'hC0); frm.push_back(8'hA8); frm.push_back(8'h01); frm.push_back(8'h09);
    frm.push_back(8'hC0); frm.push_back(8'hA8); frm.push_back(8'h01); frm.push_back(8'h02);
    frm.push_back(8'h30);     frm.push_back(8'h39);             // src port
    frm.push_back(port[15:8]); frm.push_back(port[7:0]);
    frm.push_back(ulen[15:8]); frm.push_back(ulen[7:0]);
    frm.push_back(8'h00);     frm.push_back(8'h00);             // UDP checksum
    foreach (pay_q[i]) frm.push_back(pay_q[i]);
    for (int i = 0; i < ntail; i++) frm.push_back(8'hA0 + 8'(i));
  endtask

  // Expected events of an accepted frame whose byte 0 is driven in cycle st.
  task automatic expect_accept(input int st, input int nsent, input logic [15:0] olen,
                               input logic tr);
    for (int i = 0; i < nsent; i++) push_ev(EvValid, frm[42 + i], olen, 1'b0, st + 43 + i);
    if (olen == 16'd0) push_ev(EvEnd, 8'h00, olen, 1'b0, st + 42);
    else               push_ev(EvEnd, 8'h00, olen, tr, st + 43 + nsent);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives the first n bytes of frm, then one low rx_dv cycle. When rst_at >= 0,
  // rstn is held low for two cycles starting at byte rst_at.
  task automatic send(input int n, input int rst_at);
    for (int j = 0; j < n; j++) begin
      @(posedge clk);
      #1;
      if (rst_at >= 0 && j == rst_at) begin
        rstn = 1'b0;
        #1;
        checks++;
        if ({valid, rx_end, trunc, drop, o_data, o_len} != 28'd0) begin
          failures++;
          $display("FAIL reset_midframe: got valid=%0b rx_end=%0b trunc=%0b drop=%0b data=%02h len=%0d, expected all 0",
                   valid, rx_end, trunc, drop, o_data, o_len);
        end
      end
      if (rst_at >= 0 && j == rst_at + 2) rstn = 1'b1;
      rx_dv   = 1'b1;
      rx_byte = frm[j];
    end
    @(posedge clk);
    #1;
    rx_dv   = 1'b0;
    rx_byte = 8'h00;
  endtask

  initial begin
    rstn    = 1'b1;
    rx_dv   = 1'b0;
    rx_byte = 8'h00;
    #2 rstn = 1'b0;
    idle(2);
    checks++;
    if ({valid, rx_end, trunc, drop, o_data, o_len} != 28'd0) begin
      failures++;
      $display("FAIL reset_state: got valid=%0b rx_end=%0b trunc=%0b drop=%0b data=%02h len=%0d, expected all 0",
               valid, rx_end, trunc, drop, o_data, o_len);
    end
    rstn = 1'b1;
    idle(2);

    // Accept DE AD BE EF with 18 padding + 4 FCS bytes.
    pay_q.delete();
    pay_q.push_back(8'hDE); pay_q.push_back(8'hAD); pay_q.push_back(8'hBE); pay_q.push_back(8'hEF);
    build(16'h0800, 8'h11, 16'd8080, 16'd12, 22);
    s = cyc + 1;
    expect_accept(s, 4, 16'd4, 1'b0);
    send(frm.size(), -1);
    last_len = 16'd4;
    idle(2);

    // Wrong port: drop after byte 37, o_len keeps the previous value.
    build(16'h0800, 8'h11, 16'd8081, 16'd12, 22);
    s = cyc + 1;
    push_ev(EvDrop, 8'h00, last_len, 1'b0, s + 38);
    send(frm.size(), -1);

    // ARP EtherType: drop after byte 13.
    build(16'h0806, 8'h11, 16'd8080, 16'd12, 22);
    s = cyc + 1;
    push_ev(EvDrop, 8'h00, last_len, 1'b0, s + 14);
    send(frm.size(), -1);

    // TCP protocol: drop after byte 23, then a good frame after one idle cycle.
    build(16'h0800, 8'h06, 16'd8080, 16'd12, 22);
    s = cyc + 1;
    push_ev(EvDrop, 8'h00, last_len, 1'b0, s + 24);
    send(frm.size(), -1);
    fill_pay(3, 8'h10);
    build(16'h0800, 8'h11, 16'd8080, 16'd11, 4);
    s = cyc + 1;
    expect_accept(s, 3, 16'd3, 1'b0);
    send(frm.size(), -1);
    last_len = 16'd3;

    // UDP length 8: zero-length datagram.
    pay_q.delete();
    build(16'h0800, 8'h11, 16'd8080, 16'd8, 4);
    s = cyc + 1;
    expect_accept(s, 0, 16'd0, 1'b0);
    send(frm.size(), -1);
    last_len = 16'd0;

    // UDP length 7: drop after byte 39.
    build(16'h0800, 8'h11, 16'd8080, 16'd7, 4);
    s = cyc + 1;
    push_ev(EvDrop, 8'h00, last_len, 1'b0, s + 40);
    send(frm.size(), -1);

    // Maximum payload of 1472 bytes.
    fill_pay(1472, 8'h01);
    build(16'h0800, 8'h11, 16'd8080, 16'd1480, 4);
    s = cyc + 1;
    expect_accept(s, 1472, 16'd1472, 1'b0);
    send(frm.size(), -1);
    last_len = 16'd1472;

    // Truncated payload: 50 of 100 bytes.
    fill_pay(100, 8'h40);
    build(16'h0800, 8'h11, 16'd8080, 16'd108, 0);
    s = cyc + 1;
    expect_accept(s, 50, 16'd100, 1'b1);
    send(42 + 50, -1);
    last_len = 16'd100;

    // rx_dv falls inside the header after 20 bytes.
    build(16'h0800, 8'h11, 16'd8080, 16'd12, 0);
    s = cyc + 1;
    push_ev(EvDrop, 8'h00, last_len, 1'b0, s + 21);
    send(20, -1);

    // Reset after payload byte 3: only the three earlier valids are seen.
    fill_pay(10, 8'h70);
    build(16'h0800, 8'h11, 16'd8080, 16'd18, 4);
    s = cyc + 1;
    for (int i = 0; i < 3; i++) push_ev(EvValid, frm[42 + i], 16'd10, 1'b0, s + 43 + i);
    send(frm.size(), 46);
    last_len = 16'd0;

    // Frame after the reset is accepted.
    fill_pay(5, 8'hC0);
    build(16'h0800, 8'h11, 16'd8080, 16'd13, 4);
    s = cyc + 1;
    expect_accept(s, 5, 16'd5, 1'b0);
    send(frm.size(), -1);

    idle(20);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_events: got %0d outstanding, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
